// File: rtl/extremum_scanner_pkg.sv
// Shared encodings for the extremum scanner: FSM states and scan modes.
package extremum_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/extremum_scanner_step.sv
// Combinational compare-and-select: decides whether the incoming sample
// replaces the running extremum. Strict compares keep the earlier sample on ties.
module extremum_step
    import extremum_scanner_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] acc,
    input  logic [n-1:0] in_data,
    input  logic         mode,
    output logic         take,
    output logic [n-1:0] sel_value
);

    // Unsigned strict comparison selected by mode, then mux the winner
    always_comb begin
        take      = 1'b0;
        sel_value = acc;
        if (mode == MODE_MAX) begin
            take = (in_data > acc);
        end else begin
            take = (in_data < acc);
        end
        if (take) begin
            sel_value = in_data;
        end
    end

endmodule

// File: rtl/extremum_scanner.sv
// Streaming extremum scanner: accepts len samples over a valid/ready input,
// tracks the maximum or minimum and its first index, and presents the result
// until the consumer acknowledges it.
module extremum_scanner
    import extremum_scanner_pkg::*;
#(
    parameter int n  = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          m,
    input  logic [LW-1:0] len,
    input  logic [n-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [n-1:0]  res,
    output logic [LW-1:0] pos,
    output logic          empty,
    output logic          res_valid,
    input  logic          res_ack,
    output logic          busy
);

    state_t        state;
    logic          mode_r;
    logic [LW-1:0] len_r;
    logic [n-1:0]  acc;
    logic [LW-1:0] idx;
    logic          take;
    logic [n-1:0]  sel_value;

    extremum_step #(
        .n(n)
    ) u_step (
        .acc      (acc),
        .in_data  (in_data),
        .mode     (mode_r),
        .take     (take),
        .sel_value(sel_value)
    );

    // The accumulator doubles as the result; it is held untouched in DONE
    // and forced to zero for an empty scan.
    assign res = acc;

    // Scan FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_r    <= MODE_MAX;
            len_r     <= '0;
            acc       <= '0;
            pos       <= '0;
            idx       <= '0;
            empty     <= 1'b0;
            res_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= m;
                        len_r  <= len;
                        acc    <= '0;
                        pos    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        empty  <= (len == '0);
                        if (len == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state    <= FIRST;
                            in_ready <= 1'b1;
                        end
                    end
                end
                FIRST: begin
                    if (in_valid) begin
                        acc <= in_data;
                        pos <= '0;
                        idx <= LW'(1);
                        if (len_r == LW'(1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (in_valid) begin
                        acc <= sel_value;
                        if (take) begin
                            pos <= idx;
                        end
                        // idx tops out at len-1 on the final transfer, so
                        // the increment never wraps even for len = 2^LW-1
                        idx <= idx + LW'(1);
                        if (idx == len_r - LW'(1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    if (res_ack) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_extremum_scanner.sv
// Scoreboard bench for extremum_scanner: stimulus pushes the reference
// result for each scan, a monitor compares whenever res_valid is shown.
module tb_extremum_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       m;
    logic [7:0] len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] res;
    logic [7:0] pos;
    logic       empty;
    logic       res_valid;
    logic       res_ack;
    logic       busy;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] pos;
        logic       empty;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] cur[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         xfers = 0;

    extremum_scanner #(.n(8), .LW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .len      (len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .res      (res),
        .pos      (pos),
        .empty    (empty),
        .res_valid(res_valid),
        .res_ack  (res_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: first occurrence of the max (mode 0) or min (mode 1)
    function automatic exp_t model(input logic md, input int ln);
        exp_t e;
        e.res   = 8'd0;
        e.pos   = 8'd0;
        e.empty = (ln == 0);
        if (ln > 0) begin
            e.res = cur[0];
            for (int i = 1; i < ln; i++) begin
                if ((md == 1'b0 && cur[i] > e.res) || (md == 1'b1 && cur[i] < e.res)) begin
                    e.res = cur[i];
                    e.pos = 8'(i);
                end
            end
        end
        return e;
    endfunction

    // Monitor: every cycle a result is shown it must match the oldest
    // outstanding expectation; the acknowledge retires it.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) xfers++;
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got res=%0h pos=%0h with no scan outstanding", res, pos);
            end else begin
                chk("res", 32'(res), 32'(sb[0].res));
                chk("pos", 32'(pos), 32'(sb[0].pos));
                chk("empty", 32'(empty), 32'(sb[0].empty));
                if (res_ack) void'(sb.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send(input logic [7:0] d);
        logic rdy;
        int   t = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!rdy && t < 1000);
        if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    task automatic do_start(input logic md, input int ln);
        wait_idle();
        start = 1'b1;
        m     = md;
        len   = 8'(ln);
        sb.push_back(model(md, ln));
        @(posedge clk); #1;
        start = 1'b0;
        m     = ~md;
        len   = 8'($urandom_range(0, 255));
    endtask

    task automatic run_scan(input logic md, input int ln, input int gap, input int ackdly,
                            input bit start_in_done, input bit same_cycle_start);
        int x0;
        x0 = xfers;
        do_start(md, ln);
        if (ln == 0) begin
            @(negedge clk);
            chk("empty_done_next", 32'(res_valid), 32'd1);
            chk("empty_in_ready", 32'(in_ready), 32'd0);
        end else begin
            for (int i = 0; i < ln; i++) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
                send(cur[i]);
            end
            @(negedge clk);
            chk("latency_res_valid", 32'(res_valid), 32'd1);
        end
        for (int a = 0; a < ackdly; a++) begin
            start = start_in_done;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("transfer_count", 32'(xfers - x0), 32'(ln));
        res_ack = 1'b1;
        start   = same_cycle_start;
        @(posedge clk); #1;
        res_ack = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        chk("idle_after_ack", 32'(busy), 32'd0);
        chk("res_valid_after_ack", 32'(res_valid), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_res"}, 32'(res), 32'd0);
        chk({tag, "_pos"}, 32'(pos), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        m        = 1'b0;
        len      = 8'd0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        res_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // max, tie on 9 keeps index 1
        cur = '{8'd3, 8'd9, 8'd9, 8'd2};
        run_scan(1'b0, 4, 0, 0, 1'b0, 1'b0);

        // min with two idle cycles before each sample
        cur = '{8'd200, 8'd17, 8'd255};
        run_scan(1'b1, 3, 2, 0, 1'b0, 1'b0);

        // empty scan
        cur = {};
        run_scan(1'b0, 0, 0, 1, 1'b0, 1'b0);

        // single sample, delayed ack with start pulses during DONE
        cur = '{8'hFF};
        run_scan(1'b1, 1, 0, 5, 1'b1, 1'b0);

        // reset in the middle of a scan abandons it
        cur = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        do_start(1'b0, 5);
        send(cur[0]);
        send(cur[1]);
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        check_zero("midscan_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        cur = '{8'd5, 8'd6};
        run_scan(1'b0, 2, 0, 0, 1'b0, 1'b0);

        // ack and start together: start ignored, next cycle start honoured
        cur = '{8'd4, 8'd1, 8'd7};
        run_scan(1'b1, 3, 0, 0, 1'b0, 1'b1);
        chk("same_cycle_start_ignored", 32'(sb.size()), 32'd0);
        cur = '{8'd8, 8'd8};
        run_scan(1'b0, 2, 0, 0, 1'b0, 1'b0);

        // longest scan, idx must not wrap
        cur = {};
        for (int i = 0; i < 255; i++) cur.push_back(8'($urandom_range(0, 254)));
        cur[200] = 8'hFF;
        run_scan(1'b0, 255, 0, 0, 1'b0, 1'b0);

        // random scans, narrow value range on some to provoke ties
        for (int s = 0; s < 25; s++) begin
            int ln;
            int hi;
            ln = $urandom_range(0, 12);
            hi = ($urandom_range(0, 1) == 1) ? 3 : 255;
            cur = {};
            for (int i = 0; i < ln; i++) cur.push_back(8'($urandom_range(0, hi)));
            run_scan(1'($urandom_range(0, 1)), ln, $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/extremum_scanner.md
EXTREMUM_SCANNER -- requirements
Module: extremum_scanner

Interface
REQ-001 The parameter list SHALL be exactly: n, default 8, sample/result width.
REQ-002 The parameter list SHALL also contain: LW, default 8, width of length and index fields.
REQ-003 The port list SHALL begin with: clk  input  1  sole clock, rising edge.
REQ-004 The port list SHALL continue with: rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have the port: start  input  1  request to begin a scan; honoured only in IDLE.
REQ-006 The block SHALL have the port: m  input  1  mode; 0 = maximum, 1 = minimum; sampled with start.
REQ-007 The block SHALL have the port: len  input  LW  number of samples in the scan; sampled with start.
REQ-008 The block SHALL have the port: in_data  input  n  sample value.
REQ-009 The block SHALL have the port: in_valid  input  1  in_data is valid.
REQ-010 The block SHALL have the port: in_ready  output  1  block accepts a sample this cycle.
REQ-011 The block SHALL have the port: res  output  n  extremum value.
REQ-012 The block SHALL have the port: pos  output  LW  0-based index of the extremum within the scan.
REQ-013 The block SHALL have the port: empty  output  1  the scan had len = 0.
REQ-014 The block SHALL have the port: res_valid  output  1  res, pos and empty are valid.
REQ-015 The block SHALL have the port: res_ack  input  1  consumer takes the result.
REQ-016 The block SHALL have the port: busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, FIRST, SCAN and DONE.
REQ-018 In IDLE, start=1 SHALL latch m and len; the next state SHALL be DONE with empty=1 if len=0, otherwise FIRST.
REQ-019 A sample SHALL transfer only on a cycle where in_valid=1 and in_ready=1.
REQ-020 in_ready SHALL be 1 only in FIRST and SCAN.
REQ-021 A FIRST transfer SHALL load acc=in_data, pos=0 and idx=1, then go to DONE if len=1, otherwise SCAN.
REQ-022 On a SCAN transfer in max mode, the accumulator SHALL be replaced only if in_data > acc (unsigned).
REQ-023 On a SCAN transfer in min mode, the accumulator SHALL be replaced only if in_data < acc (unsigned).
REQ-024 On any SCAN replacement, pos SHALL take the value of idx.
REQ-025 On ties, the earlier sample (acc and pos) SHALL be kept.
REQ-026 idx SHALL increment on every SCAN transfer; the transfer at idx = len-1 SHALL move the FSM to DONE.
REQ-027 res_valid SHALL rise in the cycle after the last transfer, i.e. one-cycle latency.
REQ-028 In DONE, res_valid=1 and res, pos and empty SHALL be held stable until res_ack=1; the next state SHALL then be IDLE.
REQ-029 An empty scan SHALL report res=0 and pos=0.
REQ-030 empty SHALL be cleared when the next start is accepted.
REQ-031 start outside IDLE SHALL be ignored; changes on m or len mid-scan SHALL be ignored.
REQ-032 in_valid gaps SHALL stall the scan indefinitely with no state change.
REQ-033 Back-to-back transfers SHALL sustain one sample per clock.
REQ-034 start and res_ack asserted in the same DONE cycle SHALL return the FSM to IDLE only; start SHALL NOT be captured.
REQ-035 len = 2^LW - 1 SHALL be supported; idx SHALL NOT wrap within a scan.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE and clear acc, res, pos, idx, empty, res_valid, in_ready and busy to 0, from any state.
REQ-037 A scan interrupted by reset SHALL be abandoned with no result; the first start after rst deasserts SHALL be honoured normally.

Structure
REQ-038 The state encodings and the mode encodings MODE_MAX=0 and MODE_MIN=1 SHALL be defined in a shared package or include file.
REQ-039 Compare-and-select SHALL be a combinational sub-module extremum_step (inputs acc, in_data, mode; outputs take, sel_value), parameterised by n.

Verification
REQ-040 m=0, len=4, samples 3,9,9,2 -> res=9, pos=1, res_valid one cycle after the 4th transfer.
REQ-041 m=1, len=3, samples 200,17,255 with in_valid low for 2 cycles between samples -> res=17, pos=1, no extra transfers.
REQ-042 len=0 start -> DONE next cycle, empty=1, res=0; in_ready never asserts.
REQ-043 len=1, sample 0xFF, res_ack delayed 5 cycles -> res=0xFF, pos=0, held for 5 cycles; start during DONE ignored.
REQ-044 rst pulsed after 2 of 5 samples -> IDLE, all outputs 0; new scan m=0, len=2, samples 5,6 -> res=6, pos=1.
REQ-045 Back-to-back scans with res_ack and start in the same cycle -> second start ignored; start one cycle later is accepted.
